// File: rtl/vga_capture.sv
// vga_capture: VGA sink that recovers pixel x/y/data from h_sync/v_sync/RGB332 and checks sync timing.
// Defining VGA_CAPTURE_CRC_EN builds a CRC-8 signature of each locked frame on frame_crc.
module vga_capture #(
  parameter int THADDR = 640,
  parameter int THFP   = 16,
  parameter int THS    = 96,
  parameter int THBP   = 48,
  parameter int THBD   = 0,
  parameter int TVADDR = 480,
  parameter int TVFP   = 10,
  parameter int TVS    = 2,
  parameter int TVBP   = 33,
  parameter int TVBD   = 0,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int C_SIZE = 10
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [2:0]        red,
  input  logic [2:0]        green,
  input  logic [1:0]        blue,
  // pix_valid qualifies pix_x/pix_y/pix_data for exactly one cycle; there is no ready, the sink never stalls.
  output logic              pix_valid,
  output logic [C_SIZE-1:0] pix_x,
  output logic [C_SIZE-1:0] pix_y,
  output logic [7:0]        pix_data,
  output logic              frame_start,
  output logic              locked,
  output logic              timing_err,
  output logic [7:0]        frame_crc,
  output logic [2:0]        h_state_dbg,
  output logic [2:0]        v_state_dbg
);

  typedef enum logic [2:0] {H_IDLE, H_SYNC, H_BP, H_LBD, H_ACT, H_RBD, H_FP} h_state_t;
  typedef enum logic [2:0] {V_IDLE, V_SYNC, V_BP, V_TBD, V_ACT, V_BBD, V_FP} v_state_t;

  logic              hs_s1, hs_s2, vs_s1, vs_s2;
  logic [7:0]        d_s1;
  logic              h_act1, h_act2, v_act1, v_act2, h_edge, v_edge;
  h_state_t          h_state, h_state_n;
  v_state_t          v_state, v_state_n;
  logic [C_SIZE-1:0] h_cnt, h_cnt_n, v_cnt, v_cnt_n;
  logic              h_err, v_err, seen_clean, seen_clean_n;
  logic              pix_valid_n, locked_n, timing_err_n;
  logic [C_SIZE-1:0] pix_x_n, pix_y_n;
  logic [7:0]        pix_data_n;

  // Last counter value of each state; counters restart at 0 on every state entry.
  function automatic logic [C_SIZE-1:0] h_last(input h_state_t s);
    case (s)
      H_SYNC:       h_last = C_SIZE'(THS - 1);
      H_BP:         h_last = C_SIZE'(THBP - 1);
      H_LBD, H_RBD: h_last = C_SIZE'(THBD - 1);
      H_ACT:        h_last = C_SIZE'(THADDR - 1);
      default:      h_last = C_SIZE'(THFP - 1);
    endcase
  endfunction

  function automatic logic [C_SIZE-1:0] v_last(input v_state_t s);
    case (s)
      V_SYNC:       v_last = C_SIZE'(TVS - 1);
      V_BP:         v_last = C_SIZE'(TVBP - 1);
      V_TBD, V_BBD: v_last = C_SIZE'(TVBD - 1);
      V_ACT:        v_last = C_SIZE'(TVADDR - 1);
      default:      v_last = C_SIZE'(TVFP - 1);
    endcase
  endfunction

  // Successor states, skipping zero-length porch/border segments.
  function automatic h_state_t h_follow(input h_state_t s);
    case (s)
      H_SYNC:  h_follow = (THBP != 0) ? H_BP : ((THBD != 0) ? H_LBD : H_ACT);
      H_BP:    h_follow = (THBD != 0) ? H_LBD : H_ACT;
      H_LBD:   h_follow = H_ACT;
      H_ACT:   h_follow = (THBD != 0) ? H_RBD : H_FP;
      default: h_follow = H_FP;
    endcase
  endfunction

  function automatic v_state_t v_follow(input v_state_t s);
    case (s)
      V_SYNC:  v_follow = (TVBP != 0) ? V_BP : ((TVBD != 0) ? V_TBD : V_ACT);
      V_BP:    v_follow = (TVBD != 0) ? V_TBD : V_ACT;
      V_TBD:   v_follow = V_ACT;
      V_ACT:   v_follow = (TVBD != 0) ? V_BBD : V_FP;
      default: v_follow = V_FP;
    endcase
  endfunction

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      hs_s1 <= 1'b0;
      hs_s2 <= 1'b0;
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      d_s1  <= 8'h00;
    end else begin
      hs_s1 <= h_sync;
      hs_s2 <= hs_s1;
      vs_s1 <= v_sync;
      vs_s2 <= vs_s1;
      d_s1  <= {red, green, blue};
    end
  end

  assign h_act1 = (hs_s1 == H_POL);
  assign h_act2 = (hs_s2 == H_POL);
  assign v_act1 = (vs_s1 == V_POL);
  assign v_act2 = (vs_s2 == V_POL);
  assign h_edge = h_act1 & ~h_act2;
  assign v_edge = v_act1 & ~v_act2;

  // Registered state describes the stage-1 sample of the previous cycle, aligned with the output stage.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      h_state     <= H_IDLE;
      v_state     <= V_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      seen_clean  <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= 8'h00;
    end else begin
      h_state     <= h_state_n;
      v_state     <= v_state_n;
      h_cnt       <= h_cnt_n;
      v_cnt       <= v_cnt_n;
      seen_clean  <= seen_clean_n;
      locked      <= locked_n;
      timing_err  <= timing_err_n;
      frame_start <= v_edge;
      pix_valid   <= pix_valid_n;
      pix_x       <= pix_x_n;
      pix_y       <= pix_y_n;
      pix_data    <= pix_data_n;
    end
  end

  always_comb begin
    h_state_n = h_state;
    h_cnt_n   = h_cnt + 1'b1;
    h_err     = 1'b0;
    if (h_edge) begin
      h_state_n = H_SYNC;
      h_cnt_n   = '0;
      h_err     = (h_state != H_IDLE) && !(h_state == H_FP && h_cnt == h_last(H_FP));
    end else begin
      case (h_state)
        H_IDLE: h_cnt_n = '0;
        H_SYNC: begin
          if (h_cnt == h_last(H_SYNC)) begin
            h_cnt_n = '0;
            if (h_act1) h_err = 1'b1;
            else        h_state_n = h_follow(H_SYNC);
          end else if (!h_act1) begin
            h_err     = 1'b1;
            h_state_n = H_IDLE;
            h_cnt_n   = '0;
          end
        end
        H_FP: begin
          // No sync edge after the last front-porch clock: the line is missing its sync.
          if (h_cnt == h_last(H_FP)) begin
            h_err     = 1'b1;
            h_state_n = H_IDLE;
            h_cnt_n   = '0;
          end
        end
        default: begin
          if (h_cnt == h_last(h_state)) begin
            h_state_n = h_follow(h_state);
            h_cnt_n   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    v_state_n = v_state;
    v_cnt_n   = v_cnt;
    v_err     = 1'b0;
    if (v_edge) begin
      v_state_n = V_SYNC;
      v_cnt_n   = '0;
      v_err     = (v_state != V_IDLE) && !(h_edge && v_state == V_FP && v_cnt == v_last(V_FP));
    end else if (h_edge) begin
      v_cnt_n = v_cnt + 1'b1;
      case (v_state)
        V_IDLE: v_cnt_n = '0;
        V_SYNC: begin
          if (v_cnt == v_last(V_SYNC)) begin
            v_cnt_n = '0;
            if (v_act1) v_err = 1'b1;
            else        v_state_n = v_follow(V_SYNC);
          end else if (!v_act1) begin
            v_err     = 1'b1;
            v_state_n = V_IDLE;
            v_cnt_n   = '0;
          end
        end
        V_FP: begin
          if (v_cnt == v_last(V_FP)) begin
            v_err     = 1'b1;
            v_state_n = V_IDLE;
            v_cnt_n   = '0;
          end
        end
        default: begin
          if (v_cnt == v_last(v_state)) begin
            v_state_n = v_follow(v_state);
            v_cnt_n   = '0;
          end
        end
      endcase
    end
  end

  // Lock needs two consecutive clean frame edges; any error drops it in the same cycle as the pulse.
  always_comb begin
    timing_err_n = h_err | v_err;
    seen_clean_n = seen_clean;
    locked_n     = locked;
    if (timing_err_n) begin
      seen_clean_n = 1'b0;
      locked_n     = 1'b0;
    end else if (v_edge) begin
      seen_clean_n = 1'b1;
      locked_n     = seen_clean;
    end
    pix_valid_n = locked_n && (h_state_n == H_ACT) && (v_state_n == V_ACT);
    pix_x_n     = pix_valid_n ? h_cnt_n : '0;
    pix_y_n     = pix_valid_n ? v_cnt_n : '0;
    pix_data_n  = pix_valid_n ? d_s1 : 8'h00;
  end

  assign h_state_dbg = h_state;
  assign v_state_dbg = v_state;

`ifdef VGA_CAPTURE_CRC_EN
  logic [7:0] crc_acc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      crc_acc   <= 8'h00;
      frame_crc <= 8'h00;
    end else if (frame_start) begin
      frame_crc <= crc_acc;
      crc_acc   <= 8'h00;
    end else if (pix_valid) begin
      crc_acc <= crc8_byte(crc_acc, pix_data);
    end
  end
`else
  assign frame_crc = 8'h00;
`endif

endmodule
